// File: rtl/mux_bist_sequencer.sv
// Built-in self-test sequencer for an external 4:1 multiplexer.
// Sweeps all 64 combinations of the four data inputs and two selects,
// holds each combination for SETTLE cycles, then compares the fed-back
// mux output Y against the value an ideal mux would produce.
//
// Vector index i maps onto the drive pins as {A[3],A[2],A[1],A[0],s0,s1} = i,
// and the ideal mux output is A[{s1,s0}] (s1 is the select MSB).
//
// Control handshake: start and abort are level-sampled single-cycle
// requests. start is honoured only in IDLE or DONE. abort is honoured
// only in RUN. When both are high together, abort wins and the sequencer
// lands in IDLE. No backpressure exists on the outputs; done/pass/err
// results stay stable until the next accepted start.
module mux_bist_sequencer #(
  parameter int unsigned SETTLE = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       abort,
  output logic [3:0] A,
  output logic       s0,
  output logic       s1,
  input  logic       Y,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [6:0] err_count,
  output logic       fail_valid,
  output logic [5:0] first_fail,
  output logic [5:0] vec_idx,
  output logic [1:0] dbg_state
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // The settle counter counts 0..SETTLE-1; the last value is the sample cycle.
  localparam logic [3:0] SETTLE_LAST = 4'(SETTLE - 1);
  localparam logic [5:0] LAST_VEC    = 6'd63;
  localparam logic [6:0] ERR_MAX     = 7'd64;

  state_t     state_q, state_d;
  logic [5:0] idx_q, idx_d;
  logic [3:0] cnt_q, cnt_d;
  logic [6:0] err_q, err_d;
  logic       fv_q, fv_d;
  logic [5:0] ff_q, ff_d;

  logic [3:0] a_cur;
  logic [1:0] sel_cur;
  logic       exp_y;
  logic       sample_now;
  logic       mismatch;

  // Ideal mux model for the vector currently on the pins.
  always_comb begin
    a_cur      = idx_q[5:2];
    sel_cur    = {idx_q[0], idx_q[1]};
    exp_y      = a_cur[sel_cur];
    sample_now = (state_q == RUN) && !abort && (cnt_q == SETTLE_LAST);
    mismatch   = sample_now && (Y != exp_y);
  end

  // State and datapath registers; reset clears everything to IDLE / zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      cnt_q   <= '0;
      err_q   <= '0;
      fv_q    <= 1'b0;
      ff_q    <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      fv_q    <= fv_d;
      ff_q    <= ff_d;
    end
  end

  // Next-state logic: sweep sequencing, sampling and error bookkeeping.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    fv_d    = fv_q;
    ff_d    = ff_q;

    case (state_q)
      IDLE: begin
        if (start && !abort) begin
          state_d = RUN;
          idx_d   = '0;
          cnt_d   = '0;
          err_d   = '0;
          fv_d    = 1'b0;
          ff_d    = '0;
        end
      end

      RUN: begin
        if (abort) begin
          // Results so far are kept for inspection; drive pins go back to 0.
          state_d = IDLE;
          idx_d   = '0;
          cnt_d   = '0;
        end else if (cnt_q == SETTLE_LAST) begin
          if (mismatch) begin
            if (err_q != ERR_MAX) begin
              err_d = err_q + 7'd1;
            end
            if (!fv_q) begin
              fv_d = 1'b1;
              ff_d = idx_q;
            end
          end
          cnt_d = '0;
          if (idx_q == LAST_VEC) begin
            // Last vector stays on the pins; no wrap back to vector 0.
            state_d = DONE;
          end else begin
            idx_d = idx_q + 6'd1;
          end
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end

      DONE: begin
        if (start && abort) begin
          state_d = IDLE;
          idx_d   = '0;
          cnt_d   = '0;
        end else if (start) begin
          state_d = RUN;
          idx_d   = '0;
          cnt_d   = '0;
          err_d   = '0;
          fv_d    = 1'b0;
          ff_d    = '0;
        end
      end

      default: begin
        state_d = IDLE;
        idx_d   = '0;
        cnt_d   = '0;
      end
    endcase
  end

  // Outputs are direct decodes of registered state, so they are glitch-free.
  always_comb begin
    A          = idx_q[5:2];
    s0         = idx_q[1];
    s1         = idx_q[0];
    vec_idx    = idx_q;
    busy       = (state_q == RUN);
    done       = (state_q == DONE);
    pass       = (state_q == DONE) && (err_q == 7'd0);
    err_count  = err_q;
    fail_valid = fv_q;
    first_fail = ff_q;
    dbg_state  = state_q;
  end

endmodule

// File: tb/tb_mux_bist_sequencer.sv
// Testbench for mux_bist_sequencer: two instances (SETTLE=1 and SETTLE=3)
// driving behavioural 4:1 mux models with selectable fault modes.
module tb_mux_bist_sequencer;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // ---------------- DUT 1 (SETTLE=1) ----------------
  logic       start1 = 1'b0, abort1 = 1'b0;
  logic [3:0] a1;
  logic       s0_1, s1_1, y1;
  logic       busy1, done1, pass1, fv1;
  logic [6:0] err1;
  logic [5:0] ff1, vec1;
  logic [1:0] dbg1;
  int         y_mode1 = 0;  // 0 ideal, 1 tied 0, 2 tied 1, 3 inverted at vector 37

  mux_bist_sequencer #(.SETTLE(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .abort(abort1),
    .A(a1), .s0(s0_1), .s1(s1_1), .Y(y1),
    .busy(busy1), .done(done1), .pass(pass1), .err_count(err1),
    .fail_valid(fv1), .first_fail(ff1), .vec_idx(vec1), .dbg_state(dbg1)
  );

  // ---------------- DUT 3 (SETTLE=3) ----------------
  logic       start3 = 1'b0;
  logic       abort3 = 1'b0;
  logic [3:0] a3;
  logic       s0_3, s1_3, y3;
  logic       busy3, done3, pass3, fv3;
  logic [6:0] err3;
  logic [5:0] ff3, vec3;
  logic [1:0] dbg3;

  mux_bist_sequencer #(.SETTLE(3)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .start(start3), .abort(abort3),
    .A(a3), .s0(s0_3), .s1(s1_3), .Y(y3),
    .busy(busy3), .done(done3), .pass(pass3), .err_count(err3),
    .fail_valid(fv3), .first_fail(ff3), .vec_idx(vec3), .dbg_state(dbg3)
  );

  // ---------------- mux models ----------------
  logic [1:0] sel1, sel3;
  logic       ideal1;
  always_comb begin
    sel1   = {s1_1, s0_1};
    ideal1 = a1[sel1];
    case (y_mode1)
      1:       y1 = 1'b0;
      2:       y1 = 1'b1;
      3:       y1 = ideal1 ^ (vec1 == 6'd37);
      default: y1 = ideal1;
    endcase
  end

  always_comb begin
    sel3 = {s1_3, s0_3};
    y3   = a3[sel3];
  end

  // ---------------- scoreboard ----------------
  int checks = 0;
  int failures = 0;
  // expected result word: {pass, fail_valid, first_fail[5:0], err_count[6:0]}
  logic [14:0] exp_q1[$];
  logic [14:0] exp_q3[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [14:0] mk(input logic p, input logic fv, input logic [5:0] ff,
                                     input logic [6:0] err);
    return {p, fv, ff, err};
  endfunction

  // Monitor for DUT1: on each rising done, pop and compare the result.
  logic done1_prev = 1'b0;
  always @(negedge clk) begin
    if (done1 && !done1_prev) begin
      if (exp_q1.size() == 0) begin
        chk("dut1_unexpected_done", 32'd1, 32'd0);
      end else begin
        logic [14:0] e;
        e = exp_q1.pop_front();
        chk("dut1_pass",       {31'd0, pass1}, {31'd0, e[14]});
        chk("dut1_fail_valid", {31'd0, fv1},   {31'd0, e[13]});
        chk("dut1_first_fail", {26'd0, ff1},   {26'd0, e[12:7]});
        chk("dut1_err_count",  {25'd0, err1},  {25'd0, e[6:0]});
      end
    end
    done1_prev <= done1;
  end

  // Monitor for DUT3.
  logic done3_prev = 1'b0;
  always @(negedge clk) begin
    if (done3 && !done3_prev) begin
      if (exp_q3.size() == 0) begin
        chk("dut3_unexpected_done", 32'd1, 32'd0);
      end else begin
        logic [14:0] e;
        e = exp_q3.pop_front();
        chk("dut3_pass",       {31'd0, pass3}, {31'd0, e[14]});
        chk("dut3_fail_valid", {31'd0, fv3},   {31'd0, e[13]});
        chk("dut3_first_fail", {26'd0, ff3},   {26'd0, e[12:7]});
        chk("dut3_err_count",  {25'd0, err3},  {25'd0, e[6:0]});
      end
    end
    done3_prev <= done3;
  end

  function automatic logic [28:0] outs1();
    return {a1, s0_1, s1_1, vec1, busy1, done1, pass1, err1, fv1, ff1};
  endfunction

  function automatic logic [28:0] outs3();
    return {a3, s0_3, s1_3, vec3, busy3, done3, pass3, err3, fv3, ff3};
  endfunction

  // ---------------- driver tasks ----------------
  // Full sweep on DUT1: counts busy cycles, checks vector mapping, and
  // optionally re-pulses start when vec_idx reaches restart_at.
  task automatic run_sweep1(input int mode, input logic [14:0] exp, input int restart_at);
    int nbusy = 0;
    int k = 0;
    int map_errs = 0;
    bit finished = 0;
    y_mode1 = mode;
    exp_q1.push_back(exp);
    @(negedge clk) start1 = 1'b1;
    @(negedge clk) start1 = 1'b0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      if (done1) begin
        finished = 1;
        break;
      end
      start1 = 1'b0;
      if (busy1) begin
        if (vec1 != k[5:0]) map_errs++;
        if ({a1, s0_1, s1_1} != vec1) map_errs++;
        if (restart_at >= 0 && int'(vec1) == restart_at) start1 = 1'b1;
        nbusy++;
        k++;
      end
      @(negedge clk);
    end
    start1 = 1'b0;
    chk("sweep1_finished", {31'd0, finished}, 32'd1);
    chk("sweep1_busy_cycles", nbusy, 32'd64);
    chk("sweep1_vector_map", map_errs, 32'd0);
  endtask

  task automatic run_sweep3(input logic [14:0] exp);
    int nbusy = 0;
    int prev = -1;
    int run = 0;
    int bad = 0;
    bit finished = 0;
    exp_q3.push_back(exp);
    @(negedge clk) start3 = 1'b1;
    @(negedge clk) start3 = 1'b0;
    for (int cyc = 0; cyc < 600; cyc++) begin
      if (done3) begin
        finished = 1;
        break;
      end
      if (busy3) begin
        if (int'(vec3) == prev) begin
          run++;
        end else begin
          if (prev >= 0 && run != 3) bad++;
          if (int'(vec3) != prev + 1) bad++;
          prev = int'(vec3);
          run = 1;
        end
        nbusy++;
      end
      @(negedge clk);
    end
    chk("sweep3_finished", {31'd0, finished}, 32'd1);
    chk("sweep3_busy_cycles", nbusy, 32'd192);
    chk("sweep3_vector_hold", bad, 32'd0);
    chk("sweep3_last_hold", run, 32'd3);
    chk("sweep3_last_vec", prev, 32'd63);
  endtask

  task automatic wait_vec1(input logic [5:0] target);
    bit hit = 0;
    for (int cyc = 0; cyc < 200; cyc++) begin
      @(negedge clk);
      start1 = 1'b0;
      if (busy1 && vec1 == target) begin
        hit = 1;
        break;
      end
    end
    chk("wait_vec_reached", {31'd0, hit}, 32'd1);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    repeat (3) @(negedge clk);
    chk("reset_outputs_dut1", {3'd0, outs1()}, 32'd0);
    chk("reset_outputs_dut3", {3'd0, outs3()}, 32'd0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("idle_after_reset_busy", {31'd0, busy1}, 32'd0);
    chk("idle_after_reset_done", {31'd0, done1}, 32'd0);

    // abort in IDLE has no effect
    abort1 = 1'b1;
    @(negedge clk) abort1 = 1'b0;
    chk("abort_idle_outputs", {3'd0, outs1()}, 32'd0);

    // ideal mux
    run_sweep1(0, mk(1'b1, 1'b0, 6'd0, 7'd0), -1);
    repeat (5) @(negedge clk);
    chk("done_held", {30'd0, done1, pass1}, 32'd3);

    // abort in DONE has no effect
    abort1 = 1'b1;
    @(negedge clk) abort1 = 1'b0;
    @(negedge clk);
    chk("abort_in_done_ignored", {30'd0, done1, pass1}, 32'd3);

    // stuck-at faults and a single-vector fault
    run_sweep1(1, mk(1'b0, 1'b1, 6'd4, 7'd32), -1);
    chk("pass_low_after_fail", {31'd0, pass1}, 32'd0);
    run_sweep1(2, mk(1'b0, 1'b1, 6'd0, 7'd32), -1);
    run_sweep1(3, mk(1'b0, 1'b1, 6'd37, 7'd1), -1);

    // abort at vec_idx=10 with Y tied 0: vectors 0..9 sampled, only i=4 fails
    y_mode1 = 1;
    @(negedge clk) start1 = 1'b1;
    @(negedge clk) start1 = 1'b0;
    chk("start_clears_done", {31'd0, done1}, 32'd0);
    wait_vec1(6'd10);
    abort1 = 1'b1;
    @(negedge clk) abort1 = 1'b0;
    chk("abort_drive_zero", {20'd0, a1, s0_1, s1_1, vec1}, 32'd0);
    chk("abort_busy_done", {29'd0, busy1, done1, pass1}, 32'd0);
    chk("abort_keeps_err", {25'd0, err1}, 32'd1);
    chk("abort_keeps_first", {25'd0, fv1, ff1}, {25'd0, 1'b1, 6'd4});
    repeat (3) @(negedge clk);
    chk("abort_stays_idle", {31'd0, busy1}, 32'd0);
    run_sweep1(0, mk(1'b1, 1'b0, 6'd0, 7'd0), -1);

    // abort and start together in DONE -> IDLE
    start1 = 1'b1;
    abort1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    abort1 = 1'b0;
    chk("abort_start_done_to_idle", {30'd0, busy1, done1}, 32'd0);
    // abort and start together in IDLE -> stay IDLE
    start1 = 1'b1;
    abort1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    abort1 = 1'b0;
    @(negedge clk);
    chk("abort_start_idle_stays", {30'd0, busy1, done1}, 32'd0);

    // reset mid-sweep at vec_idx=40
    y_mode1 = 0;
    @(negedge clk) start1 = 1'b1;
    @(negedge clk) start1 = 1'b0;
    wait_vec1(6'd40);
    rst_n = 1'b0;
    #1;
    chk("async_reset_outputs", {3'd0, outs1()}, 32'd0);
    @(negedge clk);
    chk("reset_held_outputs", {3'd0, outs1()}, 32'd0);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    chk("post_reset_idle", {30'd0, busy1, done1}, 32'd0);
    run_sweep1(0, mk(1'b1, 1'b0, 6'd0, 7'd0), 20);

    // SETTLE=3 instance with ideal mux
    run_sweep3(mk(1'b1, 1'b0, 6'd0, 7'd0));

    repeat (3) @(negedge clk);
    chk("queue1_drained", exp_q1.size(), 32'd0);
    chk("queue3_drained", exp_q3.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
